uart_alu_interface: RTL and testbench

Sequencing stage between the UART receiver/transmitter and the combinational ALU. Collects three serial bytes (operand A, operand B, opcode) from the UART RX, presents them as registered inputs to the ALU, captures the ALU result and hands it to the UART TX as a single byte. Sits directly upstream of the ALU's `dato_a`/`dato_b`/`op_code` inputs and directly downstream of its `o_resultado` output.

---
 rtl/uart_alu_interface.sv | 94 +++++++++
 tb/tb_uart_alu_interface.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_interface.sv
// Sequencer between UART RX/TX and the combinational ALU: gathers A, B and the opcode, then ships one result byte.
// Optional inter-byte timeout in WAIT_B/WAIT_OP is enabled by defining UART_ALU_IF_TIMEOUT_EN.
module uart_alu_interface #(
  parameter int DATA_BITS      = 8,
  parameter int OP_CODE_SIZE   = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rx_done,
  input  logic [DATA_BITS-1:0]    i_rx_data,
  input  logic                    i_tx_done,
  input  logic [DATA_BITS-1:0]    i_resultado,
  output logic [DATA_BITS-1:0]    o_dato_a,
  output logic [DATA_BITS-1:0]    o_dato_b,
  output logic [OP_CODE_SIZE-1:0] o_op_code,
  output logic                    o_tx_start,
  output logic [DATA_BITS-1:0]    o_tx_data,
  output logic                    o_busy
);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
  state_t state;

`ifdef UART_ALU_IF_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between bytes; any accepted byte, expiry or other state clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      to_cnt <= '0;
    else if ((state == WAIT_B || state == WAIT_OP) && !i_rx_done && !to_hit)
      to_cnt <= to_cnt + CW'(1);
    else
      to_cnt <= '0;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= WAIT_A;
      o_dato_a   <= '0;
      o_dato_b   <= '0;
      o_op_code  <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        WAIT_A: if (i_rx_done) begin
          o_dato_a <= i_rx_data;
          state    <= WAIT_B;
        end
        WAIT_B: begin
          if (i_rx_done) begin
            o_dato_b <= i_rx_data;
            state    <= WAIT_OP;
          end
`ifdef UART_ALU_IF_TIMEOUT_EN
          else if (to_hit) state <= WAIT_A;
`endif
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            o_op_code <= i_rx_data[OP_CODE_SIZE-1:0];
            o_busy    <= 1'b1;
            state     <= EXEC;
          end
`ifdef UART_ALU_IF_TIMEOUT_EN
          else if (to_hit) state <= WAIT_A;
`endif
        end
        // ALU inputs settled last edge; capture its result and raise start for the SEND cycle.
        EXEC: begin
          o_tx_data  <= i_resultado;
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: if (i_tx_done) begin
          o_busy <= 1'b0;
          state  <= WAIT_A;
        end
        default: state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a small ALU model closing the loop on i_resultado.
module tb_uart_alu_interface;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic [7:0] resultado;
  logic [7:0] dato_a, dato_b, tx_data;
  logic [5:0] op_code;
  logic       tx_start, busy;

  int n_vec = 0;
  int n_err = 0;

  uart_alu_interface #(.DATA_BITS(8), .OP_CODE_SIZE(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_tx_done(tx_done), .i_resultado(resultado),
    .o_dato_a(dato_a), .o_dato_b(dato_b), .o_op_code(op_code),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU (the block downstream/upstream of the DUT)
  always_comb begin
    resultado = 8'h00;
    case (op_code)
      6'h20: resultado = dato_a + dato_b;
      6'h22: resultado = dato_a - dato_b;
      6'h24: resultado = dato_a & dato_b;
      6'h25: resultado = dato_a | dato_b;
      6'h02: resultado = dato_a >> dato_b;
      default: resultado = 8'h00;
    endcase
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    n_vec++; if (dato_a !== 8'h00) begin n_err++; $display("FAIL reset_a got %h exp 00", dato_a); end
    n_vec++; if (dato_b !== 8'h00) begin n_err++; $display("FAIL reset_b got %h exp 00", dato_b); end
    n_vec++; if (op_code !== 6'h00) begin n_err++; $display("FAIL reset_op got %h exp 00", op_code); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_txd got %h exp 00", tx_data); end
    n_vec++; if ({tx_start, busy} !== 2'b00) begin n_err++; $display("FAIL reset_ctl got %b exp 00", {tx_start, busy}); end
  endtask

  task automatic test_add();
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    // EXEC cycle
    n_vec++; if (dato_a !== 8'h05) begin n_err++; $display("FAIL add_a got %h exp 05", dato_a); end
    n_vec++; if (dato_b !== 8'h03) begin n_err++; $display("FAIL add_b got %h exp 03", dato_b); end
    n_vec++; if (op_code !== 6'h20) begin n_err++; $display("FAIL add_op got %h exp 20", op_code); end
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL add_start_exec got %b exp 0", tx_start); end
    cycle(); // SEND
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL add_start_send got %b exp 1", tx_start); end
    n_vec++; if (tx_data !== 8'h08) begin n_err++; $display("FAIL add_txd got %h exp 08", tx_data); end
    cycle(); // WAIT_TX
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL add_start_width got %b exp 0", tx_start); end
    finish_tx();
  endtask

  task automatic test_sub_wrap();
    send_byte(8'h03); send_byte(8'h05);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sub_busy_waitop got %b exp 0", busy); end
    send_byte(8'h22);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sub_busy_exec got %b exp 1", busy); end
    cycle();
    n_vec++; if (tx_data !== 8'hFE) begin n_err++; $display("FAIL sub_txd got %h exp FE", tx_data); end
    repeat (4) cycle();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sub_busy_waittx got %b exp 1", busy); end
    n_vec++; if (tx_data !== 8'hFE) begin n_err++; $display("FAIL sub_txd_hold got %h exp FE", tx_data); end
    finish_tx();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sub_busy_done got %b exp 0", busy); end
  endtask

  task automatic test_opcode_mask();
    send_byte(8'h0F); send_byte(8'h3C); send_byte(8'hE4);
    n_vec++; if (op_code !== 6'h24) begin n_err++; $display("FAIL mask_op got %h exp 24", op_code); end
    cycle();
    n_vec++; if (tx_data !== 8'h0C) begin n_err++; $display("FAIL mask_txd got %h exp 0C", tx_data); end
    cycle();
    finish_tx();
  endtask

  task automatic test_busy_drop();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h25);
    cycle(); cycle(); // now WAIT_TX
    send_byte(8'h77);
    n_vec++; if (dato_a !== 8'h11) begin n_err++; $display("FAIL drop_a got %h exp 11", dato_a); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy got %b exp 1", busy); end
    finish_tx();
    // back-to-back: first cycle after WAIT_TX exit takes A
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h20);
    n_vec++; if (dato_a !== 8'h01) begin n_err++; $display("FAIL drop_next_a got %h exp 01", dato_a); end
    cycle();
    n_vec++; if (tx_data !== 8'h02) begin n_err++; $display("FAIL drop_txd got %h exp 02", tx_data); end
    cycle();
    finish_tx();
  endtask

  task automatic test_simul_done();
    tx_done = 1'b1; // outside WAIT_TX: ignored
    cycle();
    tx_done = 1'b0;
    send_byte(8'h06); send_byte(8'h02); send_byte(8'h22);
    cycle(); cycle();
    rx_done = 1'b1; rx_data = 8'h55; tx_done = 1'b1;
    cycle();
    rx_done = 1'b0; tx_done = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_busy got %b exp 0", busy); end
    n_vec++; if (dato_a !== 8'h06) begin n_err++; $display("FAIL simul_a got %h exp 06", dato_a); end
    send_byte(8'h09); send_byte(8'h04); send_byte(8'h20);
    cycle();
    n_vec++; if (tx_data !== 8'h0D) begin n_err++; $display("FAIL simul_txd got %h exp 0D", tx_data); end
    cycle();
    finish_tx();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h10); send_byte(8'h20);
    pulse_reset();
    n_vec++; if ({dato_a, dato_b, tx_data} !== 24'h0) begin n_err++; $display("FAIL rstmid_regs got %h exp 000000", {dato_a, dato_b, tx_data}); end
    n_vec++; if ({op_code, tx_start, busy} !== 8'h0) begin n_err++; $display("FAIL rstmid_ctl got %h exp 00", {op_code, tx_start, busy}); end
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h20);
    cycle();
    n_vec++; if (tx_data !== 8'h04) begin n_err++; $display("FAIL rstmid_txd got %h exp 04", tx_data); end
    // reset while start is high
    pulse_reset();
    n_vec++; if ({tx_start, busy} !== 2'b00) begin n_err++; $display("FAIL rstsend_ctl got %b exp 00", {tx_start, busy}); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rstsend_txd got %h exp 00", tx_data); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    send_byte(8'h09);
    repeat (16) cycle();
    send_byte(8'h01); send_byte(8'h02);
`ifdef UART_ALU_IF_TIMEOUT_EN
    send_byte(8'h20);
    n_vec++; if (dato_a !== 8'h01) begin n_err++; $display("FAIL tmo_a got %h exp 01", dato_a); end
    cycle();
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL tmo_start got %b exp 1", tx_start); end
    n_vec++; if (tx_data !== 8'h03) begin n_err++; $display("FAIL tmo_txd got %h exp 03", tx_data); end
`else
    send_byte(8'h20); // lands in EXEC, dropped
    n_vec++; if (dato_a !== 8'h09) begin n_err++; $display("FAIL tmo_a got %h exp 09", dato_a); end
    n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL tmo_start got %b exp 1", tx_start); end
    n_vec++; if (tx_data !== 8'h04) begin n_err++; $display("FAIL tmo_txd got %h exp 04", tx_data); end
`endif
    cycle();
    finish_tx();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_busy got %b exp 0", busy); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub_wrap();
    test_opcode_mask();
    test_busy_drop();
    test_simul_done();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
